pc_stack: RTL

Parametrised program counter with a hardware return-address stack of configurable depth. It supports sign-extended relative branches, calls and returns, absolute preload and a stall input. It sits at the front of the fetch path and drives the instruction-memory address. It is the successor to the single-entry, fixed-width PC, which could only hold one return address.

---
 rtl/pc_stack.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pc_stack.sv
// Program counter with a hardware return-address stack (jsr/ret/branch/preload/stall).
// Define PC_STACK_GUARD_EN for a guarded stack with sticky error flags; default is a circular stack.
module pc_stack #(
  parameter int ADDR_W = 11,
  parameter int REL_W  = 10,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       stall,
  input  logic                       preload,
  input  logic [ADDR_W-1:0]          preload_addr,
  input  logic                       branch,
  input  logic                       jsr,
  input  logic                       ret,
  input  logic [REL_W-1:0]           relative_addr,
  input  logic                       err_clear,
  output logic [ADDR_W-1:0]          pc,
  output logic [ADDR_W-1:0]          incr_pc,
  output logic [$clog2(DEPTH+1)-1:0] stack_count,
  output logic                       stack_overflow,
  output logic                       stack_underflow
);

  localparam int SP_W  = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] stack_mem [DEPTH];
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_dec;
  logic [ADDR_W-1:0] rel_sext;
  logic [ADDR_W-1:0] pc_next;
  logic              full;
  logic              empty;
  logic              do_push;
  logic              do_pop;
`ifdef PC_STACK_GUARD_EN
  logic              ovf_set;
  logic              unf_set;
`endif

  assign rel_sext = ADDR_W'($signed(relative_addr));
  assign sp_dec   = sp - SP_W'(1);
  assign full     = (stack_count == CNT_W'(DEPTH));
  assign empty    = (stack_count == '0);

  // Command decode in fixed priority; lower-priority commands are dropped.
  always_comb begin
    pc_next = pc + ADDR_W'(1);
    do_push = 1'b0;
    do_pop  = 1'b0;
`ifdef PC_STACK_GUARD_EN
    ovf_set = 1'b0;
    unf_set = 1'b0;
`endif
    if (jsr) begin
      pc_next = pc + rel_sext;
`ifdef PC_STACK_GUARD_EN
      if (full) ovf_set = 1'b1;
      else      do_push = 1'b1;
`else
      do_push = 1'b1;
`endif
    end else if (ret) begin
`ifdef PC_STACK_GUARD_EN
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        do_pop  = 1'b1;
        pc_next = stack_mem[sp_dec] + ADDR_W'(1);
      end
`else
      do_pop  = 1'b1;
      pc_next = stack_mem[sp_dec] + ADDR_W'(1);
`endif
    end else if (branch) begin
      pc_next = pc + rel_sext;
    end else if (preload) begin
      pc_next = preload_addr;
    end
  end

  // In the circular build a full push overwrites the oldest entry and count saturates.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= '0;
      incr_pc     <= ADDR_W'(1);
      sp          <= '0;
      stack_count <= '0;
      for (int i = 0; i < DEPTH; i++) stack_mem[i] <= '0;
    end else if (!stall) begin
      pc      <= pc_next;
      incr_pc <= pc_next + ADDR_W'(1);
      if (do_push) begin
        stack_mem[sp] <= pc;
        sp            <= sp + SP_W'(1);
        if (!full) stack_count <= stack_count + CNT_W'(1);
      end else if (do_pop) begin
        sp <= sp_dec;
        if (!empty) stack_count <= stack_count - CNT_W'(1);
      end
    end
  end

`ifdef PC_STACK_GUARD_EN
  // Sticky flags; a new error in the same cycle as err_clear wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (!stall) begin
      if (ovf_set)        stack_overflow <= 1'b1;
      else if (err_clear) stack_overflow <= 1'b0;
      if (unf_set)        stack_underflow <= 1'b1;
      else if (err_clear) stack_underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear;
  assign stack_overflow   = 1'b0;
  assign stack_underflow  = 1'b0;
`endif

endmodule
